// File: rtl/pzbcm_sram_pkg.sv
// pzbcm_sram_pkg: width and depth helpers shared by the banked SRAM blocks
package pzbcm_sram_pkg;
  function automatic int calc_pointer_width(int words);
    return (words >= 2) ? $clog2(words) : 1;
  endfunction
  function automatic int calc_bank_width(int banks);
    return (banks >= 2) ? $clog2(banks) : 1;
  endfunction
  function automatic int calc_ram_pointer_width(int words, int banks);
    return calc_pointer_width(words / banks);
  endfunction
  function automatic int calc_reader_depth(int read_latency);
    return read_latency + 2;
  endfunction
endpackage

// File: rtl/pzbcm_fifo.sv
// pzbcm_fifo: circular-buffer fifo whose output word comes straight from storage flops
module pzbcm_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  localparam int AW = (DEPTH >= 2) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    n;
  logic             full;
  function automatic logic [AW-1:0] inc(logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign valid = n != '0;
  assign full  = n == CW'(DEPTH);
  assign data  = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      n  <= '0;
    end else begin
      if (push) wp <= inc(wp);
      if (pop) rp <= inc(rp);
      n <= n + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= push_data;
  end
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && full && !pop));
  end
endmodule

// File: rtl/pzbcm_sram_reader.sv
// pzbcm_sram_reader: in-order read initiator for a banked SRAM with credit-guarded response buffer
module pzbcm_sram_reader
  import pzbcm_sram_pkg::*;
#(
  parameter int WORDS        = 64,
  parameter int DATA_WIDTH   = 32,
  parameter int BANKS        = 1,
  parameter int BANK_LSB     = 0,
  parameter int READ_LATENCY = 1,
  localparam int POINTER_WIDTH     = calc_pointer_width(WORDS),
  localparam int RAM_POINTER_WIDTH = calc_ram_pointer_width(WORDS, BANKS)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_request_valid,
  output logic                         o_request_ready,
  input  logic [POINTER_WIDTH-1:0]     i_request_address,
  output logic [BANKS-1:0]             o_sram_read_valid,
  output logic [RAM_POINTER_WIDTH-1:0] o_sram_read_address,
  input  logic [BANKS*DATA_WIDTH-1:0]  i_sram_read_data,
  output logic                         o_response_valid,
  input  logic                         i_response_ready,
  output logic [DATA_WIDTH-1:0]        o_response_data,
  output logic                         o_busy
);
  localparam int BW    = calc_bank_width(BANKS);
  localparam int DEPTH = calc_reader_depth(READ_LATENCY);
  localparam int CW    = $clog2(DEPTH + 1);
  logic [BW-1:0]                bank;
  logic [RAM_POINTER_WIDTH-1:0] ram_address;
  logic                         accept;
  logic                         pop;
  logic [CW-1:0]                count;
  logic [READ_LATENCY-1:0]      pipe_valid;
  logic [BW-1:0]                pipe_bank [READ_LATENCY];
  generate
    if (BANKS == 1) begin : g_single
      assign bank        = '0;
      assign ram_address = i_request_address;
    end else if (BANK_LSB != 0) begin : g_lsb
      assign bank        = i_request_address[BW-1:0];
      assign ram_address = i_request_address[POINTER_WIDTH-1:BW];
    end else begin : g_msb
      assign bank        = i_request_address[POINTER_WIDTH-1:RAM_POINTER_WIDTH];
      assign ram_address = i_request_address[RAM_POINTER_WIDTH-1:0];
    end
  endgenerate
  assign accept              = i_request_valid && o_request_ready;
  assign o_sram_read_valid   = accept ? BANKS'(1) << bank : '0;
  assign o_sram_read_address = ram_address;
  assign o_request_ready     = count < CW'(DEPTH);
  assign o_busy              = count != '0;
  assign pop                 = o_response_valid && i_response_ready;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count      <= '0;
      pipe_valid <= '0;
    end else begin
      count         <= count + CW'(accept) - CW'(pop);
      pipe_valid[0] <= accept;
      for (int i = 1; i < READ_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
    end
  end
  always_ff @(posedge i_clk) begin
    pipe_bank[0] <= bank;
    for (int i = 1; i < READ_LATENCY; i++) pipe_bank[i] <= pipe_bank[i-1];
  end
  pzbcm_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_response_buffer (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (pipe_valid[READ_LATENCY-1]),
    .push_data (i_sram_read_data[pipe_bank[READ_LATENCY-1]*DATA_WIDTH +: DATA_WIDTH]),
    .pop       (pop),
    .valid     (o_response_valid),
    .data      (o_response_data)
  );
endmodule

// File: tb/tb_pzbcm_sram_reader.sv
// tb_pzbcm_sram_reader: vector table, directed corner sequences and random scoreboard run
module tb_pzbcm_sram_reader;
  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         rsp_ready;
  logic [5:0]   req_addr;
  logic         a_ready, a_rsp_valid, a_busy;
  logic [3:0]   a_strobe, a_addr;
  logic [127:0] a_rdata;
  logic [31:0]  a_rsp_data;
  logic         b_ready, b_rsp_valid, b_busy;
  logic [3:0]   b_strobe, b_addr;
  logic [31:0]  b_rsp_data;
  logic         c_ready, c_rsp_valid, c_busy;
  logic [0:0]   c_strobe;
  logic [5:0]   c_addr;
  logic [31:0]  c_rsp_data;
  logic [31:0]  mem [4][16];
  logic [31:0]  d1 [4];
  logic [31:0]  d2 [4];
  logic [31:0]  exp_q [$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           n_acc = 0;
  always #5 clk = ~clk;

  pzbcm_sram_reader #(.WORDS(64), .DATA_WIDTH(32), .BANKS(4), .BANK_LSB(1), .READ_LATENCY(2)) u_a (
    .i_clk(clk), .i_rst(rst), .i_request_valid(req_valid), .o_request_ready(a_ready),
    .i_request_address(req_addr), .o_sram_read_valid(a_strobe), .o_sram_read_address(a_addr),
    .i_sram_read_data(a_rdata), .o_response_valid(a_rsp_valid), .i_response_ready(rsp_ready),
    .o_response_data(a_rsp_data), .o_busy(a_busy));
  pzbcm_sram_reader #(.WORDS(64), .DATA_WIDTH(32), .BANKS(4), .BANK_LSB(0), .READ_LATENCY(2)) u_b (
    .i_clk(clk), .i_rst(rst), .i_request_valid(req_valid), .o_request_ready(b_ready),
    .i_request_address(req_addr), .o_sram_read_valid(b_strobe), .o_sram_read_address(b_addr),
    .i_sram_read_data('0), .o_response_valid(b_rsp_valid), .i_response_ready(rsp_ready),
    .o_response_data(b_rsp_data), .o_busy(b_busy));
  pzbcm_sram_reader #(.WORDS(64), .DATA_WIDTH(32), .BANKS(1), .BANK_LSB(0), .READ_LATENCY(2)) u_c (
    .i_clk(clk), .i_rst(rst), .i_request_valid(req_valid), .o_request_ready(c_ready),
    .i_request_address(req_addr), .o_sram_read_valid(c_strobe), .o_sram_read_address(c_addr),
    .i_sram_read_data('0), .o_response_valid(c_rsp_valid), .i_response_ready(rsp_ready),
    .o_response_data(c_rsp_data), .o_busy(c_busy));

  // two-cycle SRAM: each bank registers its word on the strobe, then one output stage
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (a_strobe[b]) d1[b] <= mem[b][a_addr];
      d2[b] <= d1[b];
    end
  end
  assign a_rdata = {d2[3], d2[2], d2[1], d2[0]};

  function automatic logic [31:0] ref_word(int a);
    return mem[a % 4][a / 4];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else begin
      if (a_rsp_valid && rsp_ready) begin
        check("response_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("response_data", a_rsp_data, exp_q.pop_front());
      end
      if (req_valid && a_ready) begin
        exp_q.push_back(ref_word(req_addr));
        n_acc++;
      end
    end
  end

  typedef struct {
    logic       v;
    logic [5:0] addr;
    logic [3:0] sa;
    logic [3:0] aa;
    logic [3:0] sb;
    logic [3:0] ab;
    logic       sc;
    logic [5:0] ac;
  } vec_t;
  vec_t vt [5];

  initial begin
    int acc;
    int cyc;
    int w;
    for (int b = 0; b < 4; b++) for (int a = 0; a < 16; a++) mem[b][a] = $urandom;
    mem[1][3] = 32'hCAFE0001;
    vt[0] = '{1'b1, 6'h0D, 4'b0010, 4'd3,  4'b0001, 4'd13, 1'b1, 6'd13};
    vt[1] = '{1'b1, 6'h00, 4'b0001, 4'd0,  4'b0001, 4'd0,  1'b1, 6'd0};
    vt[2] = '{1'b1, 6'h3F, 4'b1000, 4'd15, 4'b1000, 4'd15, 1'b1, 6'd63};
    vt[3] = '{1'b1, 6'h22, 4'b0100, 4'd8,  4'b0100, 4'd2,  1'b1, 6'd34};
    vt[4] = '{1'b0, 6'h3F, 4'b0000, 4'd15, 4'b0000, 4'd15, 1'b0, 6'd63};
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1; req_addr = '0;
    @(posedge clk); @(negedge clk);
    check("reset_ready", a_ready, 1);
    check("reset_rsp_valid", a_rsp_valid, 0);
    check("reset_strobe", a_strobe, 0);
    check("reset_busy", a_busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = vt[i].v; req_addr = vt[i].addr;
      @(negedge clk);
      check("vec_strobe_lsb", a_strobe, vt[i].sa);
      check("vec_addr_lsb", a_addr, vt[i].aa);
      check("vec_strobe_msb", b_strobe, vt[i].sb);
      check("vec_addr_msb", b_addr, vt[i].ab);
      check("vec_strobe_single", c_strobe, vt[i].sc);
      check("vec_addr_single", c_addr, vt[i].ac);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 req_valid = 1'b1; req_addr = 6'h0D;
    @(negedge clk);
    check("lat_strobe", a_strobe, 4'b0010);
    check("lat_addr", a_addr, 3);
    @(posedge clk); #1 req_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("lat_rsp_valid", a_rsp_valid, k == 3);
      if (k == 3) check("lat_rsp_data", a_rsp_data, 32'hCAFE0001);
      if (k < 3) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1 acc = 0;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_addr = 6'(i);
      @(negedge clk);
      if (a_ready) acc++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("b2b_accepts", acc, 16);
    repeat (8) @(posedge clk);
    #1 acc = 0; rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_addr = 6'($urandom);
      @(negedge clk);
      if (a_ready) acc++;
      if (i == 4) check("full_ready_low", a_ready, 0);
      if (i == 5 || i == 7) begin
        check("stall_valid", a_rsp_valid, 1);
        check("stall_data", a_rsp_data, exp_q[0]);
      end
      @(posedge clk); #1;
    end
    check("full_accepts", acc, 4);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    check("ready_before_pop", a_ready, 0);
    @(posedge clk); @(negedge clk);
    check("ready_after_pop", a_ready, 1);
    repeat (8) @(posedge clk);
    #1 rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 6'(i + 5);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    check("post_reset_busy", a_busy, 0);
    check("post_reset_ready", a_ready, 1);
    for (int i = 0; i < 6; i++) begin
      check("post_reset_rsp_valid", a_rsp_valid, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    n_acc = 0; cyc = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      req_valid = $urandom_range(0, 99) < 70;
      req_addr  = 6'($urandom);
      rsp_ready = $urandom_range(0, 99) < 70;
      @(posedge clk); #1;
      cyc++;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    check("random_accepts", n_acc, 10000);
    w = 0;
    while ((exp_q.size() != 0 || a_busy) && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_busy", a_busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
